// File: rtl/move_entry.sv
// move_entry: cursor/select move entry with checker handshake and commit strobes for the game FSM
module move_entry #(
  parameter int CHK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       btn_cancel,
  input  logic [1:0] Win,
  input  logic       chk_ack,
  input  logic       chk_legal,
  input  logic       chk_mate,
  input  logic       chk_stale,
  output logic       chk_req,
  output logic [5:0] src_sq,
  output logic [5:0] dst_sq,
  output logic [5:0] cursor,
  output logic       side,
  output logic       WM,
  output logic       BM,
  output logic       WC,
  output logic       BC,
  output logic       SM,
  output logic       err,
  output logic       busy
);
  localparam int CW = $clog2(CHK_TIMEOUT + 1);
  typedef enum logic [2:0] {SEL_SRC, SEL_DST, CHECK, COMMIT, OVER} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic mate, stale, commit, mv;
  assign commit = state == COMMIT;
  assign mv = (state == SEL_SRC || state == SEL_DST) && Win == 2'b00 && !btn_cancel && !btn_sel;
  // next state: game over overrides everything, cancel beats ack, ack beats timeout
  always_comb begin
    nxt = state;
    if (Win != 2'b00) nxt = OVER;
    else
      case (state)
        SEL_SRC: nxt = (!btn_cancel && btn_sel) ? SEL_DST : SEL_SRC;
        SEL_DST: nxt = btn_cancel ? SEL_SRC : !btn_sel ? SEL_DST : (cursor == src_sq) ? SEL_SRC : CHECK;
        CHECK:   nxt = btn_cancel ? SEL_SRC : chk_ack ? (chk_legal ? COMMIT : SEL_SRC) :
                       (cnt == CW'(CHK_TIMEOUT)) ? SEL_SRC : CHECK;
        COMMIT:  nxt = (mate | stale) ? OVER : SEL_SRC;
        default: nxt = OVER;
      endcase
  end
  // state, latched squares, cursor and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEL_SRC;
      cursor <= '0;
      src_sq <= '0;
      dst_sq <= '0;
      side <= 1'b0;
      chk_req <= 1'b0;
      {WM, BM, WC, BC, SM} <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      mate <= 1'b0;
      stale <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt == CHECK || nxt == COMMIT;
      chk_req <= state == CHECK && nxt == CHECK;
      err <= state == CHECK && nxt == SEL_SRC && !btn_cancel;
      WM <= commit & ~side;
      BM <= commit & side;
      WC <= commit & ~side & mate;
      BC <= commit & side & mate;
      SM <= commit & stale;
      cnt <= state == CHECK ? cnt + 1'b1 : '0;
      if (commit) side <= ~side;
      if (state == SEL_SRC && nxt == SEL_DST) src_sq <= cursor;
      if (state == SEL_DST && nxt == CHECK) dst_sq <= cursor;
      if (state == CHECK && nxt == COMMIT) begin
        mate <= chk_mate;
        stale <= chk_stale;
      end
      if (mv) begin
        if (btn_up) cursor[5:3] <= cursor[5:3] + {2'b00, cursor[5:3] != 3'd7};
        else if (btn_down) cursor[5:3] <= cursor[5:3] - {2'b00, cursor[5:3] != 3'd0};
        else if (btn_left) cursor[2:0] <= cursor[2:0] - {2'b00, cursor[2:0] != 3'd0};
        else if (btn_right) cursor[2:0] <= cursor[2:0] + {2'b00, cursor[2:0] != 3'd7};
      end
    end
  end
endmodule

// File: tb/tb_move_entry.sv
// tb_move_entry: directed plus randomized bench against a behavioural move-entry model
module tb_move_entry;
  localparam int T = 4;
  localparam logic [5:0] B_CAN = 6'b100000, B_SEL = 6'b010000, B_UP = 6'b001000,
                         B_DN = 6'b000100, B_LF = 6'b000010, B_RT = 6'b000001;
  localparam int P_SRC = 0, P_DST = 1, P_CHECK = 2, P_COMMIT = 3, P_OVER = 4;
  logic clk = 0, reset = 0;
  logic up = 0, down = 0, left = 0, right = 0, sel = 0, cancel = 0;
  logic [1:0] win = 0;
  logic ack = 0, legal = 0, mate = 0, stale = 0;
  logic chk_req, side, wm, bm, wc, bc, sm, err, busy;
  logic [5:0] src_sq, dst_sq, cursor;
  int total = 0, bad = 0;
  int ph, mr, mf, msrc, mdst, mwait;
  bit mside, mmate, mstale, ereq, eerr, ewm, ebm, ewc, ebc, esm;
  int n_req, n_err, n_wm, n_bm, n_wc, n_bc, n_sm;

  move_entry #(.CHK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .btn_up(up), .btn_down(down), .btn_left(left), .btn_right(right),
    .btn_sel(sel), .btn_cancel(cancel), .Win(win), .chk_ack(ack), .chk_legal(legal),
    .chk_mate(mate), .chk_stale(stale), .chk_req(chk_req), .src_sq(src_sq), .dst_sq(dst_sq),
    .cursor(cursor), .side(side), .WM(wm), .BM(bm), .WC(wc), .BC(bc), .SM(sm), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return v < 0 ? 0 : v > 7 ? 7 : v;
  endfunction

  task automatic mreset();
    ph = P_SRC; mr = 0; mf = 0; msrc = 0; mdst = 0; mwait = 0;
    mside = 0; mmate = 0; mstale = 0; ereq = 0; eerr = 0;
    {ewm, ebm, ewc, ebc, esm} = '0;
  endtask

  task automatic step();
    {ewm, ebm, ewc, ebc, esm} = '0;
    eerr = 0;
    if (ph == P_COMMIT) begin
      ewm = !mside; ebm = mside; ewc = !mside && mmate; ebc = mside && mmate; esm = mstale;
      mside = !mside;
    end
    if (win != 0) begin
      ph = P_OVER; ereq = 0;
    end else if (ph == P_SRC || ph == P_DST) begin
      if (cancel) ph = P_SRC;
      else if (sel) begin
        if (ph == P_SRC) begin msrc = mr * 8 + mf; ph = P_DST; end
        else if (mr * 8 + mf == msrc) ph = P_SRC;
        else begin mdst = mr * 8 + mf; ph = P_CHECK; mwait = 0; end
      end
      else if (up) mr = clamp(mr + 1);
      else if (down) mr = clamp(mr - 1);
      else if (left) mf = clamp(mf - 1);
      else if (right) mf = clamp(mf + 1);
    end else if (ph == P_CHECK) begin
      if (cancel) begin ph = P_SRC; ereq = 0; end
      else if (ack) begin
        ereq = 0;
        if (legal) begin ph = P_COMMIT; mmate = mate; mstale = stale; end
        else begin eerr = 1; ph = P_SRC; end
      end
      else if (mwait == T) begin eerr = 1; ph = P_SRC; ereq = 0; end
      else begin ereq = 1; mwait++; end
    end else if (ph == P_COMMIT) ph = (mmate || mstale) ? P_OVER : P_SRC;
  endtask

  task automatic compare();
    check("cursor", cursor, mr * 8 + mf);
    check("src_sq", src_sq, msrc);
    check("dst_sq", dst_sq, mdst);
    check("side", side, mside);
    check("chk_req", chk_req, ereq);
    check("err", err, eerr);
    check("busy", busy, ph == P_CHECK || ph == P_COMMIT);
    check("strobes", {wm, bm, wc, bc, sm}, {ewm, ebm, ewc, ebc, esm});
    n_req += chk_req; n_err += err; n_wm += wm; n_bm += bm; n_wc += wc; n_bc += bc; n_sm += sm;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) mreset(); else step();
    #1 compare();
  endtask

  task automatic clr();
    {cancel, sel, up, down, left, right} = '0;
    {ack, legal, mate, stale} = '0;
    win = 0;
  endtask

  task automatic go(input logic [5:0] b, input logic [3:0] a);
    {cancel, sel, up, down, left, right} = b;
    {ack, legal, mate, stale} = a;
    cycle();
    clr();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic zc();
    n_req = 0; n_err = 0; n_wm = 0; n_bm = 0; n_wc = 0; n_bc = 0; n_sm = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    mreset();
    #1 compare();
    check("rst_req", chk_req, 0);
    check("rst_busy", busy, 0);
    check("rst_pos", {cursor, src_sq, dst_sq}, 0);
    check("rst_side", side, 0);
    cycle();
    reset = 1;
  endtask

  initial begin
    clr(); mreset(); zc();
    idle(2);
    reset = 1;
    check("rst_cursor", cursor, 0);
    repeat (2) go(B_UP, 0);
    repeat (4) go(B_RT, 0);
    check("cursor20", cursor, 20);
    repeat (5) go(B_DN, 0);
    check("cursor_sat", cursor, 4);
    repeat (4) go(B_LF, 0);
    zc();
    go(B_SEL, 0); go(B_RT, 0); go(B_SEL, 0);
    idle(3);
    go(0, 4'b1100);
    idle(3);
    check("w_src", src_sq, 0);
    check("w_dst", dst_sq, 1);
    check("w_req_cycles", n_req, 3);
    check("w_wm", n_wm, 1);
    check("w_bm", n_bm, 0);
    check("w_wc_sm", n_wc + n_sm, 0);
    check("w_side", side, 1);
    zc();
    go(B_SEL, 0); go(B_UP, 0); go(B_SEL, 0);
    idle(1);
    go(0, 4'b1110);
    idle(3);
    check("b_bm", n_bm, 1);
    check("b_bc", n_bc, 1);
    check("b_wm", n_wm, 0);
    zc();
    go(B_SEL, 0); go(B_SEL, 0); go(B_UP, 0);
    idle(2);
    check("over_req", n_req, 0);
    check("over_cursor", cursor, 9);
    check("over_src", src_sq, 1);
    do_reset();
    zc();
    go(B_SEL, 0); go(B_RT, 0); go(B_SEL, 0);
    idle(6);
    check("to_req_cycles", n_req, T);
    check("to_err", n_err, 1);
    check("to_strobes", n_wm + n_bm, 0);
    go(0, 4'b1100);
    idle(3);
    check("late_ack", n_wm + n_bm + n_err, 1);
    check("late_req", chk_req, 0);
    zc();
    go(B_SEL, 0); go(B_LF, 0); go(B_SEL, 0);
    idle(1);
    go(B_CAN, 4'b1100);
    idle(3);
    check("cancel_wm", n_wm + n_bm, 0);
    check("cancel_err", n_err, 0);
    check("cancel_busy", busy, 0);
    zc();
    go(B_SEL, 0); go(B_SEL, 0);
    idle(2);
    check("desel_req", n_req, 0);
    check("desel_err", n_err, 0);
    zc();
    go(B_SEL, 0);
    win = 2'b10;
    cycle();
    win = 0;
    go(B_UP, 0); go(B_SEL, 0);
    idle(2);
    check("win_cursor", cursor, 0);
    check("win_req", n_req, 0);
    do_reset();
    go(B_SEL, 0); go(B_RT, 0); go(B_SEL, 0);
    idle(2);
    check("mid_req", chk_req, 1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((ph == P_OVER && $urandom_range(0, 7) == 0) || $urandom_range(0, 599) == 0) do_reset();
      else begin
        sel = $urandom_range(0, 4) == 0;
        cancel = $urandom_range(0, 24) == 0;
        up = $urandom_range(0, 5) == 0;
        down = $urandom_range(0, 5) == 0;
        left = $urandom_range(0, 5) == 0;
        right = $urandom_range(0, 5) == 0;
        ack = ph == P_CHECK ? $urandom_range(0, 3) == 0 : $urandom_range(0, 29) == 0;
        legal = $urandom_range(0, 3) != 0;
        mate = $urandom_range(0, 7) == 0;
        stale = $urandom_range(0, 11) == 0;
        win = $urandom_range(0, 299) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
        cycle();
        clr();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/move_entry.md
# move_entry

Player move-entry and commit controller that sits directly upstream of the chess game-state FSM. It moves a square cursor from debounced button pulses and latches source and destination squares. It validates each move through a req/ack handshake with an external legality/mate checker, then emits the single-cycle WM/BM, WC/BC and SM strobes that the FSM consumes. It also consumes the FSM's Win[1:0] result and freezes once the game is over.

## Interface
- CHK_TIMEOUT, 255: maximum cycles to wait for chk_ack before the move is treated as illegal (must be ≥1).
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous reset, active-low.
- btn_up, btn_down, btn_left, btn_right  in  1 each  cursor step pulses; already debounced, one cycle wide.
- btn_sel, btn_cancel  in  1 each  select/cancel pulses; already debounced, one cycle wide.
- Win  in  2  game result from the FSM; any non-zero value means the game is over.
- chk_ack  in  1  checker response strobe.
- chk_legal, chk_mate, chk_stale  in  1 each  checker verdicts; valid only while chk_ack=1.
- chk_req  out  1  level request to the checker; held until ack, timeout or cancel.
- src_sq, dst_sq  out  6 each  latched squares, encoded as {rank[2:0], file[2:0]}.
- cursor  out  6  current cursor square.
- side  out  1  side to move: 0 = white, 1 = black.
- WM, BM, WC, BC, SM  out  1 each  one-cycle commit strobes to the FSM.
- err  out  1  one-cycle pulse on an illegal move or a timeout.
- busy  out  1  high in CHECK and COMMIT.

## Operation
- States: SEL_SRC, SEL_DST, CHECK, COMMIT, OVER.
- All outputs are registered.
- Reset values: state=SEL_SRC, cursor=0, src_sq=0, dst_sq=0, side=0, chk_req=0, all strobes=0, err=0, busy=0, timeout counter=0.
- Cursor movement applies in SEL_SRC and SEL_DST only.
  - up: rank+1; down: rank−1; right: file+1; left: file−1.
  - Saturates at the board edge; no wrap.
  - Priority when several fire together: cancel > sel > up > down > left > right. Only one action is taken per cycle.
- SEL_SRC:
  - sel: src_sq←cursor, go to SEL_DST.
  - cancel: no effect.
- SEL_DST:
  - sel with cursor==src_sq: deselect, go to SEL_SRC, no err.
  - sel with any other square: dst_sq←cursor, go to CHECK.
  - cancel: go to SEL_SRC.
- CHECK:
  - chk_req=1 and busy=1; the counter increments every cycle in CHECK.
  - chk_ack with chk_legal=1: go to COMMIT and register mate/stale.
  - chk_ack with chk_legal=0: err pulse, go to SEL_SRC.
  - Counter reaching CHK_TIMEOUT with no ack: err pulse, go to SEL_SRC.
  - cancel: go to SEL_SRC, no err.
  - Cancel and ack in the same cycle: cancel wins.
  - An ack arriving outside CHECK is ignored.
  - Direction and select buttons are ignored.
- COMMIT (exactly one cycle):
  - Pulses WM if side=0, BM if side=1.
  - WC (side=0) or BC (side=1) pulses together with it when mate=1.
  - SM pulses together with it when stale=1.
  - side toggles.
  - Next state is OVER if mate or stale, otherwise SEL_SRC.
- OVER: all buttons and acks are ignored; leaves only on reset.
- Win≠0 in any state: go to OVER next cycle, drop chk_req, emit no strobe.
- If Win≠0 coincides with COMMIT, the COMMIT strobes still fire that cycle.
- Timeout counter width is $clog2(CHK_TIMEOUT+1); it clears on every entry to CHECK.

## Timing
- Button pulse at edge N: cursor/state update visible after edge N.
- Select in SEL_DST at edge N: chk_req=1 from edge N+1.
- chk_ack sampled at edge M:
  - chk_req=0 after edge M.
  - For a legal move, the strobes are high for the cycle between edges M+1 and M+2.
- Timeout: chk_req is high for exactly CHK_TIMEOUT cycles, then err pulses for one cycle while chk_req drops.
- Strobes and err are never asserted for more than one cycle.
- WM and BM are never asserted together.
- Reset deasserting mid-operation always restarts in SEL_SRC with the reset values above.

## Test plan
- From reset, press up×2 then right×4 -> cursor=6'o24 (20). Press down×5 -> rank saturates at 0, cursor=4.
- From cursor=0, press sel, then right, then sel; checker acks after 3 cycles with legal=1, mate=0 -> src_sq=0, dst_sq=1, chk_req high 3 cycles, single WM pulse, side=1, WC=SM=0.
- Black move acked with legal=1, mate=1 -> BM and BC pulse in the same cycle, state=OVER. Further sel pulses -> no change, chk_req stays 0.
- CHK_TIMEOUT=4 with no ack -> chk_req high 4 cycles, err pulses once, state=SEL_SRC, no strobes. A late ack 2 cycles later -> ignored.
- In CHECK, cancel and ack(legal) in the same cycle -> SEL_SRC, no WM, no err. Selecting dst==src -> SEL_SRC, no chk_req.
- Drive Win=2'b10 while in SEL_DST -> OVER next cycle. Drop reset mid-CHECK -> all outputs return to their reset values.
